rf_dump_reader: RTL and testbench

- Read-side scanner for the MIPS register file: on a start pulse, walks RF addresses in ascending order through one RF read port and streams each (address, data) pair out on a valid/ready interface.
- Counterpart to the write path (d/we into reg_32bits). Used by debug/dump logic and by benches to snapshot architectural state without touching the datapath write port.
- The RF read port is combinational: rd_data is valid in the same cycle as rd_addr.

---
 rtl/rf_dump_reader.sv | 146 ++++++++++++++
 tb/tb_rf_dump_reader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_dump_reader.sv
// ---------------------------------------------------------------------------
// rf_dump_reader
// Read-side scanner for the MIPS register file. On a start pulse it walks the
// RF addresses in ascending order through one combinational read port. It
// streams each (address, data) pair out on a valid/ready interface.
//
// Build option: define RF_DUMP_SKIP_R0_EN to start the scan at address 1,
// which skips the hardwired-zero register $0.
//
// Ports
//   clk        clock, all state updates on posedge
//   reset      asynchronous active-high reset
//   start      begin a scan (sampled only while idle)
//   busy       high whenever a scan is in progress
//   done       one-cycle pulse after the last word is accepted
//   rd_addr    address to the RF read port
//   rd_data    RF read data, combinational from rd_addr
//   out_valid  out_addr/out_data hold a word
//   out_ready  consumer accepts the word when out_valid && out_ready
//   out_addr   RF address of the current word
//   out_data   RF contents captured for out_addr
//   word_cnt   words accepted in the current or last scan
// ---------------------------------------------------------------------------
module rf_dump_reader #(
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned DATA_W   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W:0]   word_cnt
);

   localparam int unsigned CNT_W = ADDR_W + 1;

`ifdef RF_DUMP_SKIP_R0_EN
   localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(1);
`else
   localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(0);
`endif
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_SEND = 2'd2
   } state_t;

   state_t              state_q,     state_d;
   logic                busy_q,      busy_d;
   logic                done_q,      done_d;
   logic                out_valid_q, out_valid_d;
   logic [ADDR_W-1:0]   rd_addr_q,   rd_addr_d;
   logic [ADDR_W-1:0]   out_addr_q,  out_addr_d;
   logic [DATA_W-1:0]   out_data_q,  out_data_d;
   logic [CNT_W-1:0]    word_cnt_q,  word_cnt_d;

   // Next-state and next-output logic.
   always_comb begin
      state_d     = state_q;
      done_d      = 1'b0;
      out_valid_d = out_valid_q;
      rd_addr_d   = rd_addr_q;
      out_addr_d  = out_addr_q;
      out_data_d  = out_data_q;
      word_cnt_d  = word_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               rd_addr_d  = FIRST;
               word_cnt_d = '0;
               state_d    = S_READ;
            end
         end
         S_READ: begin
            // Read port is combinational, so rd_data matches rd_addr_q here.
            out_data_d  = rd_data;
            out_addr_d  = rd_addr_q;
            out_valid_d = 1'b1;
            state_d     = S_SEND;
         end
         S_SEND: begin
            if (out_valid_q && out_ready) begin
               word_cnt_d  = word_cnt_q + CNT_W'(1);
               out_valid_d = 1'b0;
               if (rd_addr_q == LAST) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  rd_addr_d = rd_addr_q + ADDR_W'(1);
                  state_d   = S_READ;
               end
            end
         end
         default: begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
         end
      endcase

      // busy is registered, so it tracks the state being entered.
      busy_d = (state_d != S_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         out_valid_q <= 1'b0;
         rd_addr_q   <= '0;
         out_addr_q  <= '0;
         out_data_q  <= '0;
         word_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         out_valid_q <= out_valid_d;
         rd_addr_q   <= rd_addr_d;
         out_addr_q  <= out_addr_d;
         out_data_q  <= out_data_d;
         word_cnt_q  <= word_cnt_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign out_valid = out_valid_q;
   assign rd_addr   = rd_addr_q;
   assign out_addr  = out_addr_q;
   assign out_data  = out_data_q;
   assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_rf_dump_reader.sv
// ---------------------------------------------------------------------------
// tb_rf_dump_reader
// Directed bench for rf_dump_reader. A behavioural RF array feeds rd_data.
// Expected words are hand-derived: reg[0]=0, reg[i]=i*4+100.
// ---------------------------------------------------------------------------
module tb_rf_dump_reader;

   localparam int unsigned NUM_REGS = 32;
   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned DATA_W   = 32;

`ifdef RF_DUMP_SKIP_R0_EN
   localparam int FIRST = 1;
`else
   localparam int FIRST = 0;
`endif
   localparam int WORDS = NUM_REGS - FIRST;

   logic              clk;
   logic              reset;
   logic              start;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              out_valid;
   logic              out_ready;
   logic [ADDR_W-1:0] out_addr;
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W:0]   word_cnt;

   logic [DATA_W-1:0] rf [NUM_REGS];

   int total = 0;
   int bad   = 0;

   rf_dump_reader #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_addr  (out_addr),
      .out_data  (out_data),
      .word_cnt  (word_cnt)
   );

   assign rd_data = rf[rd_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] exp_word(input int a, input int live);
      if (a == live) return 32'd53;
      if (a == 0)    return 32'd0;
      return 32'(a * 4 + 100);
   endfunction

   task automatic rf_preload();
      for (int i = 0; i < int'(NUM_REGS); i++)
         rf[i] = (i == 0) ? 32'd0 : 32'(i * 4 + 100);
   endtask

   // Runs one full scan. bp_addr: word held with out_ready=0 for 5 cycles.
   // restart_addr: word during which a second start is pulsed.
   // live_addr: register rewritten to 53 just before its READ cycle.
   task automatic do_scan(input string nm, input int bp_addr,
                          input int restart_addr, input int live_addr);
      int  exp_a   = FIRST;
      int  dones   = 0;
      int  stall   = 0;
      int  cyc     = 0;
      int  post    = -1;
      int  last_hs = -1;
      bit  pulsed  = 1'b0;

      out_ready = 1'b1;
      start     = 1'b1;
      step();
      start     = 1'b0;
      chk({nm, " lat1_valid"}, 64'(out_valid), 64'd0);
      chk({nm, " lat1_busy"},  64'(busy),      64'd1);
      chk({nm, " cnt_clr"},    64'(word_cnt),  64'd0);
      chk({nm, " first_rd"},   64'(rd_addr),   64'(FIRST));
      step();
      chk({nm, " lat2_valid"}, 64'(out_valid), 64'd1);

      while (cyc < 400) begin
         out_ready = 1'b1;
         if (bp_addr >= 0 && out_valid && int'(out_addr) == bp_addr && stall < 5) begin
            out_ready = 1'b0;
            chk({nm, " bp_valid"}, 64'(out_valid), 64'd1);
            chk({nm, " bp_addr"},  64'(out_addr),  64'(bp_addr));
            chk({nm, " bp_data"},  64'(out_data),  64'(exp_word(bp_addr, live_addr)));
            stall++;
         end
         if (restart_addr >= 0 && out_valid && int'(out_addr) == restart_addr && !pulsed) begin
            start  = 1'b1;
            pulsed = 1'b1;
         end
         if (live_addr > 0 && out_valid && out_ready && int'(out_addr) == live_addr - 1)
            rf[live_addr] = 32'd53;
         if (done) begin
            dones++;
            post = cyc;
            chk({nm, " done_cnt"},   64'(word_cnt),  64'(WORDS));
            chk({nm, " done_busy"},  64'(busy),      64'd0);
            chk({nm, " done_valid"}, 64'(out_valid), 64'd0);
         end
         if (out_valid && out_ready) begin
            chk({nm, " addr"}, 64'(out_addr), 64'(exp_a));
            chk({nm, " data"}, 64'(out_data), 64'(exp_word(exp_a, live_addr)));
            if (bp_addr < 0 && last_hs >= 0)
               chk({nm, " gap"}, 64'(cyc - last_hs), 64'd2);
            last_hs = cyc;
            exp_a++;
         end
         step();
         start = 1'b0;
         cyc++;
         if (post >= 0 && cyc > post + 3) break;
      end

      chk({nm, " dones"},    64'(dones),    64'd1);
      chk({nm, " words"},    64'(exp_a),    64'(NUM_REGS));
      chk({nm, " cnt_hold"}, 64'(word_cnt), 64'(WORDS));
      chk({nm, " idle_busy"}, 64'(busy),    64'd0);
   endtask

   initial begin
      bit found;

      rf_preload();
      reset     = 1'b1;
      start     = 1'b0;
      out_ready = 1'b0;
      #3;
      chk("rst_busy",  64'(busy),      64'd0);
      chk("rst_done",  64'(done),      64'd0);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_rd",    64'(rd_addr),   64'd0);
      chk("rst_oaddr", 64'(out_addr),  64'd0);
      chk("rst_odata", 64'(out_data),  64'd0);
      chk("rst_cnt",   64'(word_cnt),  64'd0);
      step();
      step();
      reset = 1'b0;

      // Idle with start low.
      for (int i = 0; i < 20; i++) begin
         step();
         chk("idle_busy_valid_done", 64'({busy, out_valid, done}), 64'd0);
      end

      do_scan("full", -1, -1, -1);
      do_scan("bp_restart_live", 3, 10, 20);
      rf_preload();
      do_scan("rescan", -1, -1, -1);

      // Reset while word 7 is presented.
      out_ready = 1'b1;
      start     = 1'b1;
      step();
      start     = 1'b0;
      found     = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (out_valid && out_addr == ADDR_W'(7)) begin
            out_ready = 1'b0;
            found     = 1'b1;
            break;
         end
         step();
      end
      chk("abort_reach7", 64'(found), 64'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("abort_busy",  64'(busy),      64'd0);
      chk("abort_valid", 64'(out_valid), 64'd0);
      chk("abort_data",  64'(out_data),  64'd0);
      chk("abort_rd",    64'(rd_addr),   64'd0);
      chk("abort_done",  64'(done),      64'd0);
      step();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("post_abort_done_busy", 64'({done, busy}), 64'd0);
      end

      do_scan("after_abort", -1, -1, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
